// File: rtl/viterbi_pkg.sv
// Shared Viterbi helpers: code-bit parity, expected branch pair and metric widths.
// Reused by the ACS array and the traceback block.
package viterbi_pkg;

    localparam int unsigned MAX_K       = 7;
    localparam int unsigned BM_W        = 2;
    // Headroom bit on a candidate so a carry past PM_W can be detected and clamped.
    localparam int unsigned SAT_GUARD_W = 1;

    function automatic logic parity(input logic [MAX_K-1:0] v);
        return ^v;
    endfunction

    function automatic logic [1:0] exp_pair(input logic [MAX_K-1:0] w,
                                            input logic [MAX_K-1:0] g0,
                                            input logic [MAX_K-1:0] g1);
        return {parity(w & g1), parity(w & g0)};
    endfunction

    function automatic logic [BM_W-1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] d;
        d = a ^ b;
        return {1'b0, d[0]} + {1'b0, d[1]};
    endfunction

endpackage

// File: rtl/acs_cell.sv
// Compare-select for one trellis state: lower candidate wins, ties go to the p0 branch.
module acs_cell #(
    parameter int unsigned PM_W = 6
) (
    input  logic [PM_W-1:0] cand0,
    input  logic [PM_W-1:0] cand1,
    output logic [PM_W-1:0] surv,
    output logic            dec
);

    always_comb begin
        dec  = (cand1 < cand0);
        surv = dec ? cand1 : cand0;
    end

endmodule

// File: rtl/acs_array.sv
// Add-compare-select array for a rate-1/2 hard-decision Viterbi decoder with
// per-step metric normalisation, frame counting and a one-deep output register.
module acs_array
    import viterbi_pkg::*;
#(
    parameter int unsigned K         = 3,
    parameter int unsigned G0        = 'o7,
    parameter int unsigned G1        = 'o5,
    parameter int unsigned PM_W      = 6,
    parameter int unsigned FRAME_LEN = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              rx_sym,
    output logic                    dec_valid,
    input  logic                    dec_ready,
    output logic [(1<<(K-1))-1:0]   dec_vec,
    output logic                    frame_end,
    output logic [K-2:0]            best_state
);

    localparam int unsigned N_ST  = 1 << (K-1);
    localparam int unsigned CNT_W = $clog2(FRAME_LEN);
    localparam logic [MAX_K-1:0] G0_V = MAX_K'(G0);
    localparam logic [MAX_K-1:0] G1_V = MAX_K'(G1);
    localparam logic [PM_W-1:0]  PM_INIT = {1'b1, {(PM_W-1){1'b0}}};

    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a,
                                                input logic [BM_W-1:0] b);
        logic [PM_W+SAT_GUARD_W-1:0] sum;
        sum = {{SAT_GUARD_W{1'b0}}, a} + {{(PM_W+SAT_GUARD_W-BM_W){1'b0}}, b};
        return sum[PM_W] ? '1 : sum[PM_W-1:0];
    endfunction

    function automatic logic [PM_W-1:0] init_pm(input int unsigned s);
        return (s == 0) ? '0 : PM_INIT;
    endfunction

    logic [PM_W-1:0] pm_q [N_ST];
    logic [PM_W-1:0] pm_d [N_ST];
    logic [PM_W-1:0] surv [N_ST];
    logic [N_ST-1:0] dec_w;
    logic [PM_W-1:0] min_v;
    logic [K-2:0]    best_sel;
    logic            found;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dec_valid_q, dec_valid_d;
    logic [N_ST-1:0]  dec_vec_q, dec_vec_d;
    logic             frame_end_q, frame_end_d;
    logic [K-2:0]     best_q, best_d;
    logic             accept, last;

    assign in_ready   = !dec_valid_q | dec_ready;
    assign accept     = in_valid & in_ready;
    assign dec_valid  = dec_valid_q;
    assign dec_vec    = dec_vec_q;
    assign frame_end  = frame_end_q;
    assign best_state = best_q;

    for (genvar s = 0; s < N_ST; s++) begin : g_acs
        localparam int unsigned P0 = s >> 1;
        localparam int unsigned P1 = P0 | (N_ST / 2);
        localparam logic [MAX_K-1:0] W0 = MAX_K'((P0 << 1) | (s & 1));
        localparam logic [MAX_K-1:0] W1 = MAX_K'((P1 << 1) | (s & 1));
        logic [PM_W-1:0] cand0, cand1;

        always_comb begin
            cand0 = sat_add(pm_q[P0], hamming2(rx_sym, exp_pair(W0, G0_V, G1_V)));
            cand1 = sat_add(pm_q[P1], hamming2(rx_sym, exp_pair(W1, G0_V, G1_V)));
        end

        acs_cell #(.PM_W(PM_W)) u_cell (
            .cand0 (cand0),
            .cand1 (cand1),
            .surv  (surv[s]),
            .dec   (dec_w[s])
        );
    end

    always_comb begin
        min_v = surv[0];
        for (int unsigned s = 1; s < N_ST; s++) begin
            if (surv[s] < min_v) min_v = surv[s];
        end
        best_sel = '0;
        found    = 1'b0;
        for (int unsigned s = 0; s < N_ST; s++) begin
            if (!found && surv[s] == min_v) begin
                best_sel = (K-1)'(s);
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        pm_d        = pm_q;
        cnt_d       = cnt_q;
        dec_valid_d = dec_valid_q;
        dec_vec_d   = dec_vec_q;
        frame_end_d = frame_end_q;
        best_d      = best_q;
        last        = (cnt_q == CNT_W'(FRAME_LEN - 1));
        if (clr) begin
            for (int unsigned s = 0; s < N_ST; s++) pm_d[s] = init_pm(s);
            cnt_d       = '0;
            dec_valid_d = 1'b0;
        end else if (accept) begin
            dec_valid_d = 1'b1;
            dec_vec_d   = dec_w;
            frame_end_d = last;
            best_d      = best_sel;
            cnt_d       = last ? '0 : cnt_q + 1'b1;
            // Re-seeding on the closing step lets the next frame start from init metrics.
            for (int unsigned s = 0; s < N_ST; s++) begin
                pm_d[s] = last ? init_pm(s) : surv[s] - min_v;
            end
        end else if (dec_ready) begin
            dec_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < N_ST; s++) pm_q[s] <= init_pm(s);
            cnt_q       <= '0;
            dec_valid_q <= 1'b0;
            dec_vec_q   <= '0;
            frame_end_q <= 1'b0;
            best_q      <= '0;
        end else begin
            pm_q        <= pm_d;
            cnt_q       <= cnt_d;
            dec_valid_q <= dec_valid_d;
            dec_vec_q   <= dec_vec_d;
            frame_end_q <= frame_end_d;
            best_q      <= best_d;
        end
    end

endmodule

// File: tb/tb_acs_array.sv
// Self-checking bench: three ACS array configurations driven in lockstep and
// compared every cycle against a trellis-level reference model.
module tb_acs_array;

    localparam int NI = 3;
    localparam int K_A = 3, G0_A = 'o7,  G1_A = 'o5,  PMW_A = 6, FL_A = 8;
    localparam int K_B = 3, G0_B = 'o7,  G1_B = 'o5,  PMW_B = 6, FL_B = 4;
    localparam int K_C = 4, G0_C = 'o15, G1_C = 'o17, PMW_C = 3, FL_C = 5;

    int m_k   [NI] = '{K_A, K_B, K_C};
    int m_g0  [NI] = '{G0_A, G0_B, G0_C};
    int m_g1  [NI] = '{G1_A, G1_B, G1_C};
    int m_pmw [NI] = '{PMW_A, PMW_B, PMW_C};
    int m_fl  [NI] = '{FL_A, FL_B, FL_C};

    logic clk = 1'b0;
    logic rst, clr, in_valid, dec_ready;
    logic [1:0] rx_sym;

    logic       rdy_a, rdy_b, rdy_c, val_a, val_b, val_c, fe_a, fe_b, fe_c;
    logic [3:0] vec_a, vec_b;
    logic [7:0] vec_c;
    logic [1:0] best_a, best_b;
    logic [2:0] best_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    acs_array #(.K(K_A), .G0(G0_A), .G1(G1_A), .PM_W(PMW_A), .FRAME_LEN(FL_A)) u_dut_a (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy_a),
        .rx_sym(rx_sym), .dec_valid(val_a), .dec_ready(dec_ready), .dec_vec(vec_a),
        .frame_end(fe_a), .best_state(best_a));

    acs_array #(.K(K_B), .G0(G0_B), .G1(G1_B), .PM_W(PMW_B), .FRAME_LEN(FL_B)) u_dut_b (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy_b),
        .rx_sym(rx_sym), .dec_valid(val_b), .dec_ready(dec_ready), .dec_vec(vec_b),
        .frame_end(fe_b), .best_state(best_b));

    acs_array #(.K(K_C), .G0(G0_C), .G1(G1_C), .PM_W(PMW_C), .FRAME_LEN(FL_C)) u_dut_c (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy_c),
        .rx_sym(rx_sym), .dec_valid(val_c), .dec_ready(dec_ready), .dec_vec(vec_c),
        .frame_end(fe_c), .best_state(best_c));

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: path metrics per state as plain integers.
    int  m_pm   [NI][128];
    int  m_cnt  [NI];
    int  m_vec  [NI];
    int  m_best [NI];
    bit  m_fe   [NI];
    bit  m_valid = 1'b0;
    bit  started = 1'b0;

    task automatic m_init(input int i);
        for (int s = 0; s < (1 << (m_k[i]-1)); s++) m_pm[i][s] = (s == 0) ? 0 : (1 << (m_pmw[i]-1));
    endtask

    task automatic m_step(input int i, input logic [1:0] rx);
        int n, mx, mn, p, w, c0, c1, bm;
        int cs [2];
        int nx [128];
        n  = 1 << (m_k[i]-1);
        mx = (1 << m_pmw[i]) - 1;
        m_vec[i] = 0;
        for (int s = 0; s < n; s++) begin
            for (int j = 0; j < 2; j++) begin
                p  = (s / 2) + j * (n / 2);
                w  = p * 2 + (s % 2);
                c0 = $countones(w & m_g0[i]) % 2;
                c1 = $countones(w & m_g1[i]) % 2;
                bm = ((c0 != int'(rx[0])) ? 1 : 0) + ((c1 != int'(rx[1])) ? 1 : 0);
                cs[j] = m_pm[i][p] + bm;
                if (cs[j] > mx) cs[j] = mx;
            end
            if (cs[1] < cs[0]) begin
                nx[s] = cs[1];
                m_vec[i] = m_vec[i] | (1 << s);
            end else begin
                nx[s] = cs[0];
            end
        end
        mn = nx[0];
        for (int s = 1; s < n; s++) if (nx[s] < mn) mn = nx[s];
        m_best[i] = -1;
        for (int s = 0; s < n; s++) begin
            m_pm[i][s] = nx[s] - mn;
            if (m_best[i] < 0 && m_pm[i][s] == 0) m_best[i] = s;
        end
        m_fe[i]  = (m_cnt[i] == m_fl[i] - 1);
        m_cnt[i] = m_fe[i] ? 0 : m_cnt[i] + 1;
        if (m_fe[i]) m_init(i);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            started = 1'b1;
            m_valid = 1'b0;
            for (int i = 0; i < NI; i++) begin
                m_init(i);
                m_cnt[i] = 0; m_vec[i] = 0; m_best[i] = 0; m_fe[i] = 1'b0;
            end
        end else if (clr) begin
            m_valid = 1'b0;
            for (int i = 0; i < NI; i++) begin
                m_init(i);
                m_cnt[i] = 0;
            end
        end else if (in_valid && (!m_valid || dec_ready)) begin
            m_valid = 1'b1;
            for (int i = 0; i < NI; i++) m_step(i, rx_sym);
        end else if (dec_ready) begin
            m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            longint d_rdy [NI], d_val [NI], d_vec [NI], d_fe [NI], d_best [NI];
            d_rdy  = '{rdy_a, rdy_b, rdy_c};
            d_val  = '{val_a, val_b, val_c};
            d_vec  = '{vec_a, vec_b, vec_c};
            d_fe   = '{fe_a, fe_b, fe_c};
            d_best = '{best_a, best_b, best_c};
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("in_ready[%0d]", i), d_rdy[i], (!m_valid || dec_ready) ? 1 : 0);
                chk($sformatf("dec_valid[%0d]", i), d_val[i], m_valid ? 1 : 0);
                if (m_valid) begin
                    chk($sformatf("dec_vec[%0d]", i), d_vec[i], m_vec[i]);
                    chk($sformatf("frame_end[%0d]", i), d_fe[i], m_fe[i] ? 1 : 0);
                    chk($sformatf("best_state[%0d]", i), d_best[i], m_best[i]);
                end
            end
        end
    end

    task automatic step(input bit v, input logic [1:0] s, input bit r,
                        input bit c = 1'b0, input bit rs = 1'b0);
        in_valid = v; rx_sym = s; dec_ready = r; clr = c; rst = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Listed as (c0,c1) pairs 11,10,00,01 -> rx_sym values below.
        logic [1:0] syms [4] = '{2'b11, 2'b01, 2'b00, 2'b10};
        int         exp_best [4] = '{1, 2, 1, 3};
        int         n;

        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        chk("rst_dec_valid", val_a, 0);
        chk("rst_dec_vec", vec_a, 0);
        chk("rst_frame_end", fe_a, 0);
        chk("rst_best_state", best_a, 0);
        in_valid = 1'b0; dec_ready = 1'b0; rst = 1'b0;
        #1;
        chk("in_ready_after_rst", rdy_a, 1);

        // All-zero symbols: state 0 stays best, frame closes on the eighth step.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 2'b00, 1'b1);
            chk("zero_dec_valid", val_a, 1);
            chk("zero_dec_bit0", vec_a[0], 0);
            chk("zero_best", best_a, 0);
            chk("zero_frame_end", fe_a, (i == 7) ? 1 : 0);
            if (i == 0) chk("tie_dec_vec", vec_a, 0);
        end

        // clr together with a valid symbol: symbol dropped, output cleared.
        step(1'b1, 2'b11, 1'b1, 1'b1);
        chk("clr_dec_valid", val_a, 0);
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 4; i++) begin
                step(1'b1, syms[i], 1'b1);
                chk("short_frame_best", best_b, exp_best[i]);
                chk("short_frame_end", fe_b, (i == 3) ? 1 : 0);
            end
        end

        // Backpressure: nothing accepted while output is held.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b01, 1'b0);
            chk("stall_in_ready", rdy_a, 0);
        end
        step(1'b1, 2'b01, 1'b1);

        // Reset mid-frame, then a full fresh frame.
        step(1'b0, 2'b00, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 2'($urandom), 1'b1);
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        chk("midrst_dec_valid", val_a, 0);
        chk("midrst_dec_vec", vec_a, 0);
        chk("midrst_frame_end", fe_a, 0);
        chk("midrst_best", best_a, 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 2'($urandom), 1'b1);
            n++;
            if (fe_a) break;
        end
        chk("midrst_frame_len", n, 8);

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 49) == 0, $urandom_range(0, 149) == 0);
        end
        step(1'b0, 2'b00, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/acs_array.md
ACS_ARRAY -- requirements
Module: acs_array

Interface
REQ-001 Parameter K, default 3: constraint length, 3..7; N_ST = 2^(K-1) states.
REQ-002 Parameter G0, default 7 (octal): first generator polynomial, K bits, bit 0 = newest input.
REQ-003 Parameter G1, default 5 (octal): second generator polynomial, K bits.
REQ-004 Parameter PM_W, default 6: path-metric width, 3..12.
REQ-005 Parameter FRAME_LEN, default 8: accepted symbols per frame, 2..1023.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 clr  in  1  synchronous soft restart of frame and metrics; outputs unchanged except as REQ-027 states.
REQ-009 in_valid  in  1  rx_sym valid.
REQ-010 in_ready  out  1  block accepts rx_sym this cycle.
REQ-011 rx_sym  in  2  hard-decision received pair {c1,c0}.
REQ-012 dec_valid  out  1  dec_vec/frame_end/best_state valid.
REQ-013 dec_ready  in  1  consumer accepts output.
REQ-014 dec_vec  out  N_ST  survivor decision per state; bit s = 1 selects upper predecessor.
REQ-015 frame_end  out  1  this output is the last step of a frame.
REQ-016 best_state  out  K-1  minimum-metric state after this step.

Function
REQ-017 Accept = in_valid & in_ready; in_ready = !dec_valid | dec_ready, combinational.
REQ-018 Output register: set dec_valid on accept; clear it on dec_ready without accept; hold all outputs while dec_valid & !dec_ready; latency 1 cycle from accept.
REQ-019 Trellis: next state = ((p<<1)|b) & (N_ST-1); predecessors of s: p0 = s>>1, p1 = (s>>1) | N_ST/2; input bit b = s[0].
REQ-020 Expected pair for branch p->s: w = (p<<1)|b over K bits; c0 = parity(w & G0); c1 = parity(w & G1).
REQ-021 Branch metric = Hamming distance of rx_sym to {c1,c0}, 0..2.
REQ-022 Candidate metric = PM[p] + BM in PM_W+1 bits, saturated to 2^PM_W-1.
REQ-023 dec_vec[s] = 0 when cand(p0) <= cand(p1) (tie picks p0), else 1; survivor = selected candidate.
REQ-024 Normalisation: every accept, subtract minimum survivor from all survivors before storing; stored minimum is always 0.
REQ-025 best_state = lowest-index state whose normalised survivor is 0.
REQ-026 Frame counter counts accepts 0..FRAME_LEN-1; frame_end = 1 on the step where counter was FRAME_LEN-1; counter then wraps to 0.
REQ-027 Metric init (reset, clr, and first accept after a frame_end step): PM[0] = 0, PM[s!=0] = 2^(PM_W-1); first step of a frame uses init metrics, not the previous frame's.
REQ-028 clr with accept in same cycle: clr wins, symbol dropped, in_ready still 1 for that cycle; clr also clears dec_valid.
REQ-029 rst mid-frame: discard frame, no frame_end emitted.

Reset
REQ-030 On rst: dec_valid = 0, dec_vec = 0, frame_end = 0, best_state = 0, counter = 0, metrics per REQ-027.
REQ-031 in_ready = 1 in the cycle after rst deasserts.

Structure
REQ-032 Shared package viterbi_pkg holds parity function, branch-expected-pair function, and saturating-add width constants reused by the traceback block.
REQ-033 One sub-module acs_cell (two candidates in, survivor and decision out) instantiated N_ST times via generate; min tree and normalisation stay in acs_array.

Verification
REQ-034 K=3, G=7/5, eight rx_sym=00 with dec_ready=1 -> eight dec_valid pulses, dec_vec[0]=0 each step, best_state=0, frame_end on 8th only.
REQ-035 FRAME_LEN=4, rx_sym 11,10,00,01 -> best_state 1,2,1,3; frame_end on 4th; next frame restarts from init metrics.
REQ-036 dec_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs held stable, no symbol lost; resumes in order.
REQ-037 Equal candidates forced (rx_sym=01 from all-init-equal metrics via clr then equal-bias config) -> dec bit 0.
REQ-038 rst asserted after 5 accepts of an 8-frame -> all outputs per REQ-030, next frame_end after 8 further accepts.
REQ-039 PM_W=3, 20 random noisy symbols vs reference model -> metrics never wrap, dec_vec and best_state match model every step.
